// File: rtl/uart_seq_tx.sv
// uart_seq_tx -- UART transmitter with built-in incrementing test-pattern source.
//
// Sending end of the link-integrity test: each frame carries the previous
// payload value + 1, so the receiver can detect dropped or corrupted bytes.
// Frames are 8N1 (PARITY=0) or 8E1 (PARITY=1), LSB first, idle high.
//
// Optional feature macro: UART_SEQ_TX_HAMMING_EN
//   When defined, the sequence value is a 4-bit code. Each payload is its
//   Hamming(7,4) codeword with bit 7 set, and inject_err flips payload bit 0
//   of the next frame instead of skipping a value.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-low
//   enable     in   level; high starts or continues transmission
//   burst_len  in   frames per burst, 0 = continuous (latched on IDLE->LOAD)
//   inject_err in   pulse; sticky until the next LOAD
//   tx         out  serial line, idle high
//   tx_busy    out  high from LOAD through end of GAP
//   byte_sent  out  one-cycle pulse at the end of each stop bit
//   last_byte  out  payload of the most recent completed frame
//   sent_count out  frames completed in the current burst (saturating)
//   done       out  high while in DONE
module uart_seq_tx #(
   parameter int         BAUD_RATE   = 4,
   parameter int         PARITY      = 0,
   parameter int         GAP_CYCLES  = 16,
   parameter logic [7:0] START_VALUE = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] burst_len,
   input  logic        inject_err,
   output logic        tx,
   output logic        tx_busy,
   output logic        byte_sent,
   output logic [7:0]  last_byte,
   output logic [15:0] sent_count,
   output logic        done
);

   localparam int BW       = $clog2(BAUD_RATE);
   localparam int GW       = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
   localparam int GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
   localparam logic [BW-1:0] BIT_END = BW'(BAUD_RATE - 1);
   localparam logic [GW-1:0] GAP_END = GW'(GAP_LAST);
`ifdef UART_SEQ_TX_HAMMING_EN
   localparam int VW = 4;
`else
   localparam int VW = 8;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_DATA, S_PAR, S_STOP, S_GAP, S_DONE
   } state_t;

   state_t          state_r;
   state_t          exit_state_s;
   logic [VW-1:0]   value_r;
   logic [VW-1:0]   value_next_s;
   logic [7:0]      shreg_r;
   logic [7:0]      load_byte_s;
   logic [15:0]     burst_len_r;
   logic [15:0]     count_inc_s;
   logic [15:0]     count_cmp_s;
   logic            inj_r;
   logic            inj_eff_s;
   logic            burst_end_s;
   logic [BW-1:0]   bit_cnt_r;
   logic [2:0]      bit_idx_r;
   logic [GW-1:0]   gap_cnt_r;

   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

`ifdef UART_SEQ_TX_HAMMING_EN
   function automatic logic [7:0] hamming_enc(input logic [3:0] c);
      logic p1;
      logic p2;
      logic p3;
      p1 = c[0] ^ c[1] ^ c[3];
      p2 = c[0] ^ c[2] ^ c[3];
      p3 = c[1] ^ c[2] ^ c[3];
      return {1'b1, c[3], c[2], c[1], p3, c[0], p2, p1};
   endfunction
`endif

   // Payload for the next frame and the sequence value that follows it.
   // A pulse arriving in the LOAD cycle itself is honoured by that LOAD.
   always_comb begin
      inj_eff_s = inj_r | inject_err;
`ifdef UART_SEQ_TX_HAMMING_EN
      load_byte_s  = hamming_enc(value_r) ^ {7'b0000000, inj_eff_s};
      value_next_s = value_r + 4'h1;
`else
      load_byte_s  = value_r + {7'b0000000, inj_eff_s};
      value_next_s = load_byte_s + 8'h01;
`endif
   end

   // End-of-frame decision; with no gap it is taken on the last stop clock,
   // before sent_count has absorbed the increment, so compare the next count.
   always_comb begin
      count_inc_s  = (sent_count == 16'hFFFF) ? sent_count : sent_count + 16'h0001;
      count_cmp_s  = (GAP_CYCLES == 0) ? count_inc_s : sent_count;
      burst_end_s  = (burst_len_r != 16'h0000) && (count_cmp_s == burst_len_r);
      exit_state_s = S_IDLE;
      if (burst_end_s) begin
         exit_state_s = S_DONE;
      end else if (enable) begin
         exit_state_s = S_LOAD;
      end else begin
         exit_state_s = S_IDLE;
      end
   end

   // Sequencer FSM, serializer and registered status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= S_IDLE;
         tx          <= 1'b1;
         tx_busy     <= 1'b0;
         byte_sent   <= 1'b0;
         last_byte   <= 8'h00;
         sent_count  <= 16'h0000;
         done        <= 1'b0;
         value_r     <= START_VALUE[VW-1:0];
         inj_r       <= 1'b0;
         shreg_r     <= 8'h00;
         burst_len_r <= 16'h0000;
         bit_cnt_r   <= '0;
         bit_idx_r   <= 3'd0;
         gap_cnt_r   <= '0;
      end else begin
         byte_sent <= 1'b0;
         if (inject_err) begin
            inj_r <= 1'b1;
         end
         case (state_r)
            S_IDLE: begin
               tx      <= 1'b1;
               tx_busy <= 1'b0;
               done    <= 1'b0;
               if (enable) begin
                  burst_len_r <= burst_len;
                  sent_count  <= 16'h0000;
                  value_r     <= START_VALUE[VW-1:0];
                  tx_busy     <= 1'b1;
                  state_r     <= S_LOAD;
               end
            end
            S_LOAD: begin
               tx        <= 1'b1;
               tx_busy   <= 1'b1;
               shreg_r   <= load_byte_s;
               value_r   <= value_next_s;
               inj_r     <= 1'b0;
               bit_cnt_r <= '0;
               state_r   <= S_START;
            end
            S_START: begin
               tx <= 1'b0;
               if (bit_cnt_r == BIT_END) begin
                  bit_cnt_r <= '0;
                  bit_idx_r <= 3'd0;
                  state_r   <= S_DATA;
               end else begin
                  bit_cnt_r <= bit_cnt_r + BW'(1);
               end
            end
            S_DATA: begin
               tx <= shreg_r[bit_idx_r];
               if (bit_cnt_r == BIT_END) begin
                  bit_cnt_r <= '0;
                  if (bit_idx_r == 3'd7) begin
                     state_r <= (PARITY != 0) ? S_PAR : S_STOP;
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                  end
               end else begin
                  bit_cnt_r <= bit_cnt_r + BW'(1);
               end
            end
            S_PAR: begin
               tx <= even_parity(shreg_r);
               if (bit_cnt_r == BIT_END) begin
                  bit_cnt_r <= '0;
                  state_r   <= S_STOP;
               end else begin
                  bit_cnt_r <= bit_cnt_r + BW'(1);
               end
            end
            S_STOP: begin
               tx <= 1'b1;
               if (bit_cnt_r == BIT_END) begin
                  bit_cnt_r  <= '0;
                  byte_sent  <= 1'b1;
                  last_byte  <= shreg_r;
                  sent_count <= count_inc_s;
                  if (GAP_CYCLES != 0) begin
                     gap_cnt_r <= '0;
                     state_r   <= S_GAP;
                  end else begin
                     state_r <= exit_state_s;
                     tx_busy <= (exit_state_s == S_LOAD);
                     done    <= (exit_state_s == S_DONE);
                  end
               end else begin
                  bit_cnt_r <= bit_cnt_r + BW'(1);
               end
            end
            S_GAP: begin
               tx <= 1'b1;
               if (gap_cnt_r == GAP_END) begin
                  state_r <= exit_state_s;
                  tx_busy <= (exit_state_s == S_LOAD);
                  done    <= (exit_state_s == S_DONE);
               end else begin
                  gap_cnt_r <= gap_cnt_r + GW'(1);
               end
            end
            S_DONE: begin
               tx      <= 1'b1;
               tx_busy <= 1'b0;
               done    <= 1'b1;
               if (!enable) begin
                  done    <= 1'b0;
                  state_r <= S_IDLE;
               end
            end
            default: begin
               tx      <= 1'b1;
               tx_busy <= 1'b0;
               done    <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_seq_tx.sv
// Directed testbench for uart_seq_tx. Four instances with different
// parameter sets share clk/reset/burst_len; each has its own enable and
// inject_err. A serial sampler reads frames off the selected tx line.
module tb_uart_seq_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [15:0] burst_len;
   logic        en_a, en_p, en_w, en_h;
   logic        inj_a, inj_p, inj_w, inj_h;
   logic        tx_a, tx_p, tx_w, tx_h;
   logic        busy_a, busy_p, busy_w, busy_h;
   logic        bs_a, bs_p, bs_w, bs_h;
   logic [7:0]  lb_a, lb_p, lb_w, lb_h;
   logic [15:0] sc_a, sc_p, sc_w, sc_h;
   logic        done_a, done_p, done_w, done_h;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int npulse_a = 0;
   int sel = 0;
   logic tx_sel;

   uart_seq_tx #(.BAUD_RATE(4), .PARITY(0), .GAP_CYCLES(16), .START_VALUE(8'h00)) dut_a (
      .clk(clk), .reset(reset), .enable(en_a), .burst_len(burst_len), .inject_err(inj_a),
      .tx(tx_a), .tx_busy(busy_a), .byte_sent(bs_a), .last_byte(lb_a), .sent_count(sc_a), .done(done_a));
   uart_seq_tx #(.BAUD_RATE(4), .PARITY(1), .GAP_CYCLES(16), .START_VALUE(8'h07)) dut_p (
      .clk(clk), .reset(reset), .enable(en_p), .burst_len(burst_len), .inject_err(inj_p),
      .tx(tx_p), .tx_busy(busy_p), .byte_sent(bs_p), .last_byte(lb_p), .sent_count(sc_p), .done(done_p));
   uart_seq_tx #(.BAUD_RATE(4), .PARITY(0), .GAP_CYCLES(0), .START_VALUE(8'hFE)) dut_w (
      .clk(clk), .reset(reset), .enable(en_w), .burst_len(burst_len), .inject_err(inj_w),
      .tx(tx_w), .tx_busy(busy_w), .byte_sent(bs_w), .last_byte(lb_w), .sent_count(sc_w), .done(done_w));
   uart_seq_tx #(.BAUD_RATE(4), .PARITY(0), .GAP_CYCLES(16), .START_VALUE(8'h06)) dut_h (
      .clk(clk), .reset(reset), .enable(en_h), .burst_len(burst_len), .inject_err(inj_h),
      .tx(tx_h), .tx_busy(busy_h), .byte_sent(bs_h), .last_byte(lb_h), .sent_count(sc_h), .done(done_h));

   always_comb begin
      case (sel)
         0: tx_sel = tx_a;
         1: tx_sel = tx_p;
         2: tx_sel = tx_w;
         default: tx_sel = tx_h;
      endcase
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bs_a === 1'b1) npulse_a <= npulse_a + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Wait (negedge-sampled) for the start bit; returns on the negedge of its first cycle.
   task automatic wait_fall(output int t);
      int n;
      n = 0;
      @(negedge clk);
      while (tx_sel !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (tx_sel !== 1'b0) begin
         errors++;
         $display("FAIL wait_fall: tx=%b after %0d cycles, required 0", tx_sel, n);
      end
      t = cyc;
   endtask

   // Sample a frame at mid-bit; off = negedges already elapsed since start-bit cycle 0.
   task automatic rx_bits(input int off, input bit par, output logic [7:0] d,
                          output logic p, output logic s);
      repeat (2 - off) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         repeat (4) @(negedge clk);
         d[i] = tx_sel;
      end
      p = 1'b0;
      if (par) begin
         repeat (4) @(negedge clk);
         p = tx_sel;
      end
      repeat (4) @(negedge clk);
      s = tx_sel;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b required 1", tx_a); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy_a); end
      checks++; if (bs_a !== 1'b0) begin errors++; $display("FAIL rst_byte_sent: got %b required 0", bs_a); end
      checks++; if (lb_a !== 8'h00) begin errors++; $display("FAIL rst_last_byte: got %h required 00", lb_a); end
      checks++; if (sc_a !== 16'h0000) begin errors++; $display("FAIL rst_count: got %h required 0000", sc_a); end
      checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done_a); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_basic;
      logic [7:0] d; logic p; logic s;
      int f0, f1, f2, n;
      logic [7:0] exp_b [3];
      exp_b[0] = 8'h00; exp_b[1] = 8'h01; exp_b[2] = 8'h02;
      sel = 0;
      burst_len = 16'd3;
      @(negedge clk);
      en_a = 1'b1;
      @(posedge clk); #1;
      checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL lat_e0: tx=%b required 1", tx_a); end
      @(posedge clk); #1;
      checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL lat_e1: tx=%b required 1", tx_a); end
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL busy_load: got %b required 1", busy_a); end
      @(posedge clk); #1;
      checks++; if (tx_a !== 1'b0) begin errors++; $display("FAIL lat_e2: tx=%b required 0", tx_a); end
      f0 = cyc;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            wait_fall(f1);
            checks++;
            if (f1 - f0 != 57) begin errors++; $display("FAIL basic_period%0d: got %0d required 57", k, f1 - f0); end
            f0 = f1;
         end
         rx_bits(0, 1'b0, d, p, s);
         checks++; if (d !== exp_b[k]) begin errors++; $display("FAIL basic_byte%0d: got %h required %h", k, d, exp_b[k]); end
         checks++; if (s !== 1'b1) begin errors++; $display("FAIL basic_stop%0d: got %b required 1", k, s); end
      end
      n = 0;
      while (done_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL basic_done: got %b required 1", done_a); end
      checks++; if (sc_a !== 16'd3) begin errors++; $display("FAIL basic_count: got %0d required 3", sc_a); end
      checks++; if (lb_a !== 8'h02) begin errors++; $display("FAIL basic_last: got %h required 02", lb_a); end
      checks++; if (npulse_a != 3) begin errors++; $display("FAIL basic_pulses: got %0d required 3", npulse_a); end
      f2 = 0;
      for (int i = 0; i < 80; i++) begin @(negedge clk); if (tx_a !== 1'b1) f2++; end
      checks++; if (f2 != 0) begin errors++; $display("FAIL basic_no_4th: %0d low cycles required 0", f2); end
      en_a = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL basic_done_clr: got %b required 0", done_a); end
   endtask

   task automatic test_parity;
      logic [7:0] d; logic p; logic s;
      int f0, f1, n;
      sel = 1;
      burst_len = 16'd2;
      @(negedge clk);
      en_p = 1'b1;
      wait_fall(f0);
      rx_bits(0, 1'b1, d, p, s);
      checks++; if (d !== 8'h07) begin errors++; $display("FAIL par_byte0: got %h required 07", d); end
      checks++; if (p !== 1'b1) begin errors++; $display("FAIL par_bit0: got %b required 1", p); end
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL par_stop0: got %b required 1", s); end
      wait_fall(f1);
      checks++; if (f1 - f0 != 61) begin errors++; $display("FAIL par_period: got %0d required 61", f1 - f0); end
      rx_bits(0, 1'b1, d, p, s);
      checks++; if (d !== 8'h08) begin errors++; $display("FAIL par_byte1: got %h required 08", d); end
      checks++; if (p !== 1'b1) begin errors++; $display("FAIL par_bit1: got %b required 1", p); end
      n = 0;
      while (done_p !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      checks++; if (sc_p !== 16'd2) begin errors++; $display("FAIL par_count: got %0d required 2", sc_p); end
      en_p = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_wrap_inject;
      logic [7:0] d; logic p; logic s;
      int f0, f1, n;
      sel = 2;
      burst_len = 16'd0;
      @(negedge clk);
      en_w = 1'b1;
      wait_fall(f0);
      // two pulses inside the first frame must still skip only one value
      inj_w = 1'b1; @(posedge clk); #1; inj_w = 1'b0;
      @(negedge clk);
      inj_w = 1'b1; @(posedge clk); #1; inj_w = 1'b0;
      @(negedge clk);
      rx_bits(2, 1'b0, d, p, s);
      checks++; if (d !== 8'hFE) begin errors++; $display("FAIL wrap_byte0: got %h required FE", d); end
      wait_fall(f1);
      checks++; if (f1 - f0 != 41) begin errors++; $display("FAIL wrap_period: got %0d required 41", f1 - f0); end
      checks++; if (lb_w !== 8'hFE) begin errors++; $display("FAIL wrap_last0: got %h required FE", lb_w); end
      rx_bits(0, 1'b0, d, p, s);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL wrap_byte1: got %h required 00", d); end
      wait_fall(f1);
      checks++; if (lb_w !== 8'h00) begin errors++; $display("FAIL wrap_last1: got %h required 00", lb_w); end
      en_w = 1'b0;
      rx_bits(0, 1'b0, d, p, s);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL wrap_byte2: got %h required 01", d); end
      n = 0;
      while (busy_w !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      checks++; if (busy_w !== 1'b0) begin errors++; $display("FAIL wrap_busy_end: got %b required 0", busy_w); end
      n = 0;
      for (int i = 0; i < 50; i++) begin @(negedge clk); if (tx_w !== 1'b1) n++; end
      checks++; if (n != 0) begin errors++; $display("FAIL wrap_idle_tx: %0d low cycles required 0", n); end
      checks++; if (lb_w !== 8'h01) begin errors++; $display("FAIL wrap_last2: got %h required 01", lb_w); end
      checks++; if (sc_w !== 16'd3) begin errors++; $display("FAIL wrap_count: got %0d required 3", sc_w); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] d; logic p; logic s;
      int f0, f1, n;
      sel = 2;
      burst_len = 16'd2;
      @(negedge clk);
      en_w = 1'b1;
      wait_fall(f0);
      rx_bits(0, 1'b0, d, p, s);
      checks++; if (d !== 8'hFE) begin errors++; $display("FAIL b2b_byte0: got %h required FE", d); end
      wait_fall(f1);
      checks++; if (f1 - f0 != 41) begin errors++; $display("FAIL b2b_period: got %0d required 41", f1 - f0); end
      rx_bits(0, 1'b0, d, p, s);
      checks++; if (d !== 8'hFF) begin errors++; $display("FAIL b2b_byte1: got %h required FF", d); end
      n = 0;
      while (done_w !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++; if (done_w !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b required 1", done_w); end
      checks++; if (sc_w !== 16'd2) begin errors++; $display("FAIL b2b_count: got %0d required 2", sc_w); end
      en_w = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_enable_drop;
      int f0, n, base;
      sel = 0;
      burst_len = 16'd0;
      @(negedge clk);
      en_a = 1'b1;
      wait_fall(f0);
      base = npulse_a;
      repeat (12) @(negedge clk);
      en_a = 1'b0;
      n = 0;
      while (busy_a !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b required 0", busy_a); end
      checks++; if (npulse_a != base + 1) begin errors++; $display("FAIL drop_pulses: got %0d required %0d", npulse_a, base + 1); end
      checks++; if (lb_a !== 8'h00) begin errors++; $display("FAIL drop_last: got %h required 00", lb_a); end
      checks++; if (sc_a !== 16'd1) begin errors++; $display("FAIL drop_count: got %0d required 1", sc_a); end
      n = 0;
      for (int i = 0; i < 30; i++) begin @(negedge clk); if (tx_a !== 1'b1) n++; end
      checks++; if (n != 0) begin errors++; $display("FAIL drop_idle_tx: %0d low cycles required 0", n); end
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] d; logic p; logic s;
      int f0;
      sel = 0;
      burst_len = 16'd0;
      @(negedge clk);
      en_a = 1'b1;
      wait_fall(f0);
      repeat (10) @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b required 1", tx_a); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy_a); end
      @(negedge clk);
      reset = 1'b1;
      wait_fall(f0);
      rx_bits(0, 1'b0, d, p, s);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL midrst_restart: got %h required 00", d); end
      en_a = 1'b0;
      repeat (30) @(negedge clk);
   endtask

   task automatic test_hamming;
      logic [7:0] d; logic p; logic s;
      int f0;
      sel = 3;
      burst_len = 16'd0;
      @(negedge clk);
      inj_h = 1'b1;
      @(negedge clk);
      inj_h = 1'b0;
      en_h = 1'b1;
      for (int k = 0; k < 11; k++) begin
         wait_fall(f0);
         if (k == 10) begin
            checks++; if (lb_h !== 8'hFF) begin errors++; $display("FAIL ham_last_F: got %h required FF", lb_h); end
            en_h = 1'b0;
         end
         rx_bits(0, 1'b0, d, p, s);
         if (k == 0) begin
            checks++; if (d !== 8'hB2) begin errors++; $display("FAIL ham_inj6: got %h required B2", d); end
         end else if (k == 1) begin
            checks++; if (d !== 8'hB4) begin errors++; $display("FAIL ham_code7: got %h required B4", d); end
         end else if (k == 9) begin
            checks++; if (d !== 8'hFF) begin errors++; $display("FAIL ham_codeF: got %h required FF", d); end
         end else if (k == 10) begin
            checks++; if (d !== 8'h80) begin errors++; $display("FAIL ham_code0: got %h required 80", d); end
         end
      end
      repeat (30) @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      burst_len = 16'd0;
      en_a = 1'b0; en_p = 1'b0; en_w = 1'b0; en_h = 1'b0;
      inj_a = 1'b0; inj_p = 1'b0; inj_w = 1'b0; inj_h = 1'b0;
      test_reset();
`ifdef UART_SEQ_TX_HAMMING_EN
      test_hamming();
`else
      test_basic();
      test_parity();
      test_wrap_inject();
      test_back_to_back();
      test_enable_drop();
      test_reset_mid_frame();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_seq_tx.md
Name: uart_seq_tx

Overview:
- Self-contained UART transmitter plus test-pattern generator. It is the sending end of the link-integrity test, whose receiving end checks that each byte equals the previous byte + 1.
- Emits a configurable burst, or a continuous stream, of incrementing bytes.
- Supports deliberate sequence-error injection.
- Sits on the board's TX gpio. Frame format is compatible with the existing uart_rx: 8N1, or 8E1 with parity.

Parameters:
- BAUD_RATE, 4, clocks per bit (4 = BAUD6M_CLK24M); legal values >= 2
- PARITY, 0, 0 = no parity bit, 1 = even parity bit after data
- GAP_CYCLES, 16, idle-high clocks between frames; 0 = back-to-back
- START_VALUE, 8'h00, first byte of a burst

Ports:
- clk  in  1  system clock (24 MHz from HFOSC)
- reset  in  1  synchronous, active-low; reset=0 resets the block
- enable  in  1  level; high starts or continues transmission
- burst_len  in  16  frames per burst; 0 = continuous
- inject_err  in  1  single-cycle pulse; the next loaded byte skips one value
- tx  out  1  serial line, idle high
- tx_busy  out  1  high from LOAD through end of GAP
- byte_sent  out  1  one-cycle pulse at end of each stop bit
- last_byte  out  8  payload of the most recent completed frame
- sent_count  out  16  frames completed in the current burst
- done  out  1  high in DONE state

Behaviour:
- Reset values (reset=0 at a clk edge): tx=1, tx_busy=0, byte_sent=0, last_byte=0, sent_count=0, done=0, state=IDLE, value=START_VALUE, inject flag cleared. Reset mid-frame drives tx high on the same edge and abandons the frame.
- State IDLE:
  - On enable=1, latch burst_len, clear sent_count, set value=START_VALUE, go to LOAD.
- State LOAD (1 cycle):
  - shreg = value, or value+1 if the inject flag is set.
  - Then value = shreg+1, mod 256, wrapping 8'hFF -> 8'h00.
  - Clear the inject flag; tx_busy=1.
- State START: tx=0 for BAUD_RATE clocks.
- State DATA: 8 bits, LSB first, each BAUD_RATE clocks.
- State PAR (only if PARITY=1): tx = XOR of the 8 data bits (even parity), BAUD_RATE clocks.
- State STOP: tx=1 for BAUD_RATE clocks. On the last clock:
  - byte_sent=1 for one cycle
  - last_byte=shreg
  - sent_count += 1, saturating at 16'hFFFF
- State GAP: tx=1 for GAP_CYCLES clocks; skipped if GAP_CYCLES=0. Exit:
  - if burst_len!=0 and sent_count==burst_len, go to DONE
  - else if enable=1, go to LOAD
  - else go to IDLE
  - tx_busy=0 on leaving GAP.
- State DONE: done=1, tx=1. Go to IDLE when enable=0.
- Timing and latency:
  - tx falls 2 clocks after the edge that samples enable=1 in IDLE.
  - Frame length = (10+PARITY)*BAUD_RATE clocks.
  - Frame period = frame length + GAP_CYCLES (+1 for LOAD).
- Boundary conditions:
  - enable dropping mid-frame: the current frame completes normally.
  - inject_err arriving during a frame: held sticky until the next LOAD. Multiple pulses before that LOAD still skip only one value.
  - inject_err and reset asserted together: reset wins.
  - burst_len changes mid-burst: ignored until the next IDLE->LOAD.
- Bit-period counter width: clog2(BAUD_RATE). Gap counter width: clog2(GAP_CYCLES+1).

Optional Feature:
- Macro: UART_SEQ_TX_HAMMING_EN
- Defined:
  - value becomes a 4-bit code wrapping 4'hF -> 4'h0, starting at START_VALUE[3:0].
  - Payload = {1'b1, d3, d2, d1, p3, d0, p2, p1}, where p1=d0^d1^d3, p2=d0^d2^d3, p3=d1^d2^d3.
  - inject_err instead flips payload bit 0 of the next frame (a single-bit error the receiver must correct).
  - last_byte reports the transmitted payload.
- Not defined: raw 8-bit incrementing payload as above; no encoder logic synthesized.

Test Plan:
- Basic frame: BAUD_RATE=4, PARITY=0, GAP=16, burst_len=3, enable held high -> bytes 00,01,02 on tx, each 40-clock frame LSB first. tx falls 2 clocks after enable is sampled. 3 byte_sent pulses, then done=1 with sent_count=3.
- Parity: PARITY=1, START_VALUE=8'h07 -> the first frame's parity bit is 1 and the frame is 44 clocks. The second byte, 8'h08, has parity bit 1.
- Wrap and injection: START_VALUE=8'hFE, continuous, inject_err pulsed during the first frame -> sequence FE,00,01 (FF skipped). last_byte tracks each value.
- Enable drop and reset: drop enable mid-DATA -> the frame completes, then IDLE with tx=1. Assert reset=0 mid-frame -> tx=1 and tx_busy=0 on the next edge, and the restart sends START_VALUE.
- Hamming (macro defined): START_VALUE=8'h06 -> first payload 8'hB3. Code 4'hF -> 8'hFF. inject_err -> 8'hB2 for code 6.
- Back-to-back: GAP_CYCLES=0, burst_len=2 -> the second start bit follows the first stop bit after exactly 1 idle-high clock (the LOAD cycle).
